// File: rtl/aes_pkg.sv
// Shared AES definitions for the sequential key schedule.
// Contains the S-box table, xtime, key-size derivations and the FSM state type.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  localparam logic [0:255][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic int nk_of(input int key_bits);
    return key_bits / 32;
  endfunction

  function automatic int nr_of(input int key_bits);
    return key_bits / 32 + 6;
  endfunction

  function automatic int nw_of(input int key_bits);
    return 4 * (key_bits / 32 + 7);
  endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
module aes_sbox_word
  import aes_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign dout[8*b +: 8] = sbox(din[8*b +: 8]);
  end

endmodule

// File: rtl/aes_key_sched_seq.sv
// Sequential AES-128/192/256 key schedule: one schedule word per cycle, round keys streamed out.
// Optional KEYSCHED_STORE_EN keeps every accepted round key in a readable register file.
module aes_key_sched_seq
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);

  localparam int NK = nk_of(KEY_BITS);
  localparam int NR = nr_of(KEY_BITS);
  localparam int NW = nw_of(KEY_BITS);
  localparam logic [5:0] NK_W  = 6'(NK);
  localparam logic [2:0] NK_M1 = 3'(NK - 1);
  localparam logic [5:0] NW_W  = 6'(NW);
  localparam logic [3:0] NR_W  = 4'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
    $error("KEY_BITS must be 128, 192 or 256");
  end

  state_e       state_q, state_d;
  logic [5:0]   i_q, i_d;
  logic [2:0]   k_q, k_d;        // i mod NK
  logic [7:0]   rcon_q, rcon_d;
  logic [31:0]  win_q [NK];      // win_q[0] = w[i-NK] ... win_q[NK-1] = w[i-1]
  logic [31:0]  win_d [NK];
  logic [31:0]  stg_q [3];
  logic [31:0]  stg_d [3];
  logic         rk_valid_q, rk_valid_d;
  logic [127:0] rk_data_q, rk_data_d;
  logic [3:0]   rk_idx_q, rk_idx_d;

  logic [31:0] t_last, sub_in, sub_out, t_mix, w_new;
  logic        out_free, accept, gen_en;
  logic        unused_key;

  // Stream: a key transfers on a rising edge where rk_valid && rk_ready; while
  // rk_valid && !rk_ready the data and index hold and the generator stalls at slot 3.
  assign out_free = !rk_valid_q || rk_ready;
  assign accept   = rk_valid_q && rk_ready;
  assign gen_en   = (state_q == ST_GEN) && (i_q < NW_W) && ((i_q[1:0] != 2'd3) || out_free);

  assign t_last = win_q[NK-1];
  assign sub_in = (k_q == 3'd0) ? {t_last[23:0], t_last[31:24]} : t_last;

  aes_sbox_word u_sbox (
    .din  (sub_in),
    .dout (sub_out)
  );

  always_comb begin
    t_mix = t_last;
    if (k_q == 3'd0) begin
      t_mix = sub_out ^ {rcon_q, 24'h0};
    end else if (NK == 8 && k_q == 3'd4) begin
      t_mix = sub_out;
    end
    // The first NK words rotate through the window, leaving it holding the key again at i=NK.
    w_new = (i_q < NK_W) ? win_q[0] : (win_q[0] ^ t_mix);
  end

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    k_d        = k_q;
    rcon_d     = rcon_q;
    win_d      = win_q;
    stg_d      = stg_q;
    rk_valid_d = rk_valid_q;
    rk_data_d  = rk_data_q;
    rk_idx_d   = rk_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          for (int j = 0; j < NK; j++) win_d[j] = key_in[255-32*j -: 32];
          i_d     = '0;
          k_d     = '0;
          rcon_d  = 8'h01;
          state_d = ST_GEN;
        end
      end
      ST_GEN: begin
        if (accept) rk_valid_d = 1'b0;
        if (gen_en) begin
          for (int j = 0; j < NK - 1; j++) win_d[j] = win_q[j+1];
          win_d[NK-1] = w_new;
          i_d = i_q + 6'd1;
          k_d = (k_q == NK_M1) ? 3'd0 : k_q + 3'd1;
          if (i_q >= NK_W && k_q == 3'd0) rcon_d = xtime(rcon_q);
          if (i_q[1:0] == 2'd3) begin
            rk_data_d  = {stg_q[0], stg_q[1], stg_q[2], w_new};
            rk_idx_d   = i_q[5:2];
            rk_valid_d = 1'b1;
          end else begin
            stg_d[i_q[1:0]] = w_new;
          end
        end
        if (accept && rk_idx_q == NR_W) state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      i_q        <= '0;
      k_q        <= '0;
      rcon_q     <= 8'h01;
      rk_valid_q <= 1'b0;
      rk_data_q  <= '0;
      rk_idx_q   <= '0;
      for (int j = 0; j < NK; j++) win_q[j] <= '0;
      for (int j = 0; j < 3; j++) stg_q[j] <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      k_q        <= k_d;
      rcon_q     <= rcon_d;
      win_q      <= win_d;
      stg_q      <= stg_d;
      rk_valid_q <= rk_valid_d;
      rk_data_q  <= rk_data_d;
      rk_idx_q   <= rk_idx_d;
    end
  end

  assign busy       = (state_q == ST_GEN);
  assign done       = (state_q == ST_FIN);
  assign rk_valid   = rk_valid_q;
  assign rk_data    = rk_data_q;
  assign rk_idx     = rk_idx_q;
  assign unused_key = ^key_in;

`ifdef KEYSCHED_STORE_EN
  logic [127:0] store_q [NR+1];
  logic [127:0] store_d [NR+1];

  always_comb begin
    store_d = store_q;
    if (accept) store_d[rk_idx_q] = rk_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j <= NR; j++) store_q[j] <= '0;
    end else begin
      store_q <= store_d;
    end
  end

  assign rd_key = (rd_idx <= NR_W) ? store_q[rd_idx] : '0;
`else
  logic unused_rd;
  assign unused_rd = ^rd_idx;
  assign rd_key    = '0;
`endif

endmodule

// File: tb/tb_aes_key_sched_seq.sv
// Bench for aes_key_sched_seq: three instances (AES-128/192/256) share the stimulus;
// known-answer vectors plus a GF(2^8)-derived reference schedule model.
module tb_aes_key_sched_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         rk_ready = 1'b1;
  logic [255:0] key_in = '0;
  logic [3:0]   rd_idx = '0;
  logic         busy [3];
  logic         done [3];
  logic         rk_valid [3];
  logic [127:0] rk_data [3];
  logic [3:0]   rk_idx [3];
  logic [127:0] rd_key [3];

  aes_key_sched_seq #(.KEY_BITS(128)) u_dut128 (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .busy(busy[0]), .done(done[0]),
    .rk_valid(rk_valid[0]), .rk_ready(rk_ready), .rk_data(rk_data[0]), .rk_idx(rk_idx[0]),
    .rd_idx(rd_idx), .rd_key(rd_key[0]));
  aes_key_sched_seq #(.KEY_BITS(192)) u_dut192 (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .busy(busy[1]), .done(done[1]),
    .rk_valid(rk_valid[1]), .rk_ready(rk_ready), .rk_data(rk_data[1]), .rk_idx(rk_idx[1]),
    .rd_idx(rd_idx), .rd_key(rd_key[1]));
  aes_key_sched_seq #(.KEY_BITS(256)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .busy(busy[2]), .done(done[2]),
    .rk_valid(rk_valid[2]), .rk_ready(rk_ready), .rk_data(rk_data[2]), .rk_idx(rk_idx[2]),
    .rd_idx(rd_idx), .rd_key(rd_key[2]));

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // reference model: S-box from GF(2^8) inverse + affine map, textbook expansion
  logic [7:0]   m_sbox [256];
  logic [127:0] model_rk [3][15];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int r);
    return (v << r) | (v >> (8 - r));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      m_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {m_sbox[v[31:24]], m_sbox[v[23:16]], m_sbox[v[15:8]], m_sbox[v[7:0]]};
  endfunction

  task automatic model_expand(input int n, input logic [255:0] key);
    int nk = 4 + 2 * n;
    int nr = nk + 6;
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) model_rk[n][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // scoreboard
  logic [131:0] exp_q0[$], exp_q1[$], exp_q2[$];
  logic [127:0] got_key [3][15];
  int  acc_cnt [3];
  int  last_nr_cyc [3];
  bit  done_seen [3];
  int  start_cyc = -100;
  bit  lat_pending = 1'b0;
  int  mode = 0;
  int  acc3_cyc = 0;

  task automatic q_pop(input int n, output logic [131:0] v, output bit ok);
    ok = 1'b0;
    v  = '0;
    case (n)
      0: if (exp_q0.size() > 0) begin v = exp_q0.pop_front(); ok = 1'b1; end
      1: if (exp_q1.size() > 0) begin v = exp_q1.pop_front(); ok = 1'b1; end
      default: if (exp_q2.size() > 0) begin v = exp_q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  task automatic q_reset();
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
    for (int n = 0; n < 3; n++) begin
      acc_cnt[n]     = 0;
      last_nr_cyc[n] = -10;
      done_seen[n]   = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    logic [131:0] e;
    bit ok;
    bit exp_done;
    if (rst_n) begin
      if (lat_pending && rk_valid[0]) begin
        check("latency", 256'(cyc - start_cyc), 256'd5);
        lat_pending = 1'b0;
      end
      if (cyc == start_cyc + 1)
        check("busy_after_start", {busy[0], busy[1], busy[2]}, 3'b111);
      for (int n = 0; n < 3; n++) begin
        exp_done = (last_nr_cyc[n] == cyc - 1);
        if (done[n] || exp_done) begin
          check("done_pulse", {done[n], busy[n]}, {exp_done, 1'b0});
          if (done[n]) done_seen[n] = 1'b1;
        end
        if (rk_valid[n] && rk_ready) begin
          q_pop(n, e, ok);
          if (!ok) check("unexpected_key", {rk_idx[n], rk_data[n]}, '0);
          else check("round_key", {rk_idx[n], rk_data[n]}, e);
          if (rk_idx[n] < 15) got_key[n][rk_idx[n]] = rk_data[n];
          if (rk_idx[n] == 4'(10 + 2 * n)) last_nr_cyc[n] = cyc;
          if (n == 0 && rk_idx[n] == 4'd3) acc3_cyc = cyc;
          if (n == 0 && rk_idx[n] == 4'd4 && mode == 1)
            check("stall_resume", 256'(cyc - acc3_cyc), 256'd1);
          acc_cnt[n]++;
        end
      end
    end
  end

  // driver tasks
  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom();
    return k;
  endfunction

  task automatic check_all_zero(input string name);
    for (int n = 0; n < 3; n++)
      check(name, {busy[n], done[n], rk_valid[n], rk_idx[n], rk_data[n], rd_key[n]}, '0);
  endtask

  // md: 0 ready high, 1 seven-cycle stall at rk3, 2 random ready, 3 reset after rk4, 4 start while busy
  task automatic run_sched(input logic [255:0] key, input int md);
    int budget = 0;
    int stall_left = 0;
    bit stall_done = 1'b0;
    q_reset();
    mode = md;
    for (int n = 0; n < 3; n++) begin
      model_expand(n, key);
      for (int r = 0; r <= 10 + 2 * n; r++) begin
        case (n)
          0: exp_q0.push_back({4'(r), model_rk[0][r]});
          1: exp_q1.push_back({4'(r), model_rk[1][r]});
          default: exp_q2.push_back({4'(r), model_rk[2][r]});
        endcase
      end
    end
    rk_ready = 1'b1;
    key_in = key;
    start = 1'b1;
    start_cyc = cyc;
    lat_pending = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    key_in = rand_key();
    while (!(done_seen[0] && done_seen[1] && done_seen[2]) && budget < 600) begin
      start = 1'b0;
      rk_ready = 1'b1;
      if (md == 1) begin
        if (stall_left > 0) begin
          rk_ready = 1'b0;
          stall_left--;
          check("hold_rk3", {rk_idx[0], rk_data[0]}, {4'd3, model_rk[0][3]});
        end else if (!stall_done && rk_valid[0] && rk_idx[0] == 4'd3) begin
          stall_done = 1'b1;
          stall_left = 6;
          rk_ready = 1'b0;
          check("hold_rk3", {rk_idx[0], rk_data[0]}, {4'd3, model_rk[0][3]});
        end
      end else if (md == 2) begin
        rk_ready = ($urandom_range(0, 3) != 0);
      end else if (md == 3 && acc_cnt[0] >= 5) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_abort");
        q_reset();
        lat_pending = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end else if (md == 4 && budget == 8) begin
        start = 1'b1;
        key_in = rand_key();
      end
      @(posedge clk); #1;
      budget++;
    end
    start = 1'b0;
    rk_ready = 1'b1;
    check("run_complete", {done_seen[0], done_seen[1], done_seen[2]}, 3'b111);
    check("exp_q_drained", 256'(exp_q0.size() + exp_q1.size() + exp_q2.size()), '0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [255:0] key;
    int           inst;
    int           ridx;
    logic [127:0] exp;
  } vec_t;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{K128, 0, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[1] = '{K128, 0, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2] = '{K128, 0, 2,  128'hf2c295f27a96b9435935807a7359f67f};
    vecs[3] = '{K128, 0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[4] = '{K192, 1, 0,  128'h8e73b0f7da0e6452c810f32b809079e5};
    vecs[5] = '{K192, 1, 12, 128'he98ba06f448c773c8ecc720401002202};
    vecs[6] = '{K256, 2, 1,  128'h1f352c073b6108d72d9810a30914dff4};
    vecs[7] = '{K256, 2, 14, 128'hfe4890d1e6188d0b046df344706c631e};
    build_sbox();
    q_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 8; v++) begin
      run_sched(vecs[v].key, 0);
      check($sformatf("kat_%0d_rk%0d", vecs[v].inst, vecs[v].ridx),
            got_key[vecs[v].inst][vecs[v].ridx], vecs[v].exp);
    end

`ifdef KEYSCHED_STORE_EN
    run_sched(K128, 0);
    rd_idx = 4'd10; #1;
    check("store_rk10", rd_key[0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd_idx = 4'd11; #1;
    check("store_beyond_nr", rd_key[0], '0);
    rd_idx = 4'd15; #1;
    check("store_idx15", {rd_key[0], rd_key[1], rd_key[2]}, '0);
    rd_idx = 4'd12; #1;
    check("store_192_rk12", rd_key[1], model_rk[1][12]);
    rd_idx = 4'd0;
`endif

    run_sched(K128, 1);
    run_sched(K128, 3);
    run_sched(K128, 0);
    check("after_abort_rk10", got_key[0][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_sched(rand_key(), 4);
    for (int r = 0; r < 6; r++) run_sched(rand_key(), 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
